fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Instruction buffer between the IF stage and the decode stage (IDUnit).
//  Decouples fetch from decode stalls by holding fetched instructions with
//  their PC and branch-prediction info.
//  Presents the oldest entry to IDUnit's inst1_i. Drains it when decode is
//  not stalled. Flushes on a front-end kill.
// PARAMETERS
//  DEPTH     4   number of entries; power of 2, >= 2
//  INSN_LEN  32  instruction width
//  ADDR_LEN  32  PC / predicted-target width
// PORTS
//  clk_i           in   1         clock; all state updates on posedge
//  reset_i         in   1         asynchronous, active-high reset
//  kill_IF         in   1         flush: discard all entries and any same-cycle push
//  push_valid_i    in   1         IF presents a fetched instruction this cycle
//  inst_i          in   INSN_LEN  fetched instruction
//  pc_i            in   ADDR_LEN  PC of inst_i
//  pred_taken_i    in   1         branch predicted taken
//  pred_addr_i     in   ADDR_LEN  predicted next PC
//  ready_o         out  1         queue can accept a push (count < DEPTH)
//  stall_ID        in   1         decode is stalled; hold the head entry
//  valid_o         out  1         head entry is valid
//  inst1_o         out  INSN_LEN  head instruction; feeds IDUnit inst1_i
//  pc_o            out  ADDR_LEN  head PC
//  pred_taken_o    out  1         head prediction flag
//  pred_addr_o     out  ADDR_LEN  head predicted target
//  count_o         out  clog2(DEPTH)+1  number of occupied entries
// BEHAVIOUR
//  - Storage: circular buffer with head/tail pointers of width clog2(DEPTH)
//    and a separate count register. Pointers wrap from DEPTH-1 to 0.
//  - push = push_valid_i & ready_o & ~kill_IF
//  - pop  = valid_o & ~stall_ID & ~kill_IF
//  - ready_o = (count < DEPTH). It does not depend on a same-cycle pop, so
//    there is no full-bypass.
//  - valid_o = (count != 0).
//  - Head outputs are driven combinationally from the storage entry at the
//    head pointer.
//  - When empty, the head outputs are forced to:
//      inst1_o = 32'h00000013 (NOP), pc_o = 0, pred_taken_o = 0, pred_addr_o = 0
//  - Latency: an entry pushed at edge N is visible on valid_o/inst1_o after
//    edge N. There is no same-cycle IF-to-output bypass.
//  - Push and pop in the same cycle: both pointers advance; count unchanged.
//    When full, a pop alone frees a slot for the next cycle.
//  - Push while full: blocked (ready_o = 0). The queue never overwrites.
//  - Pop while empty: impossible, because valid_o = 0.
//  - Pushed data is written into the slot at the tail pointer.
//  - Pop advances only the head pointer; stored data is not cleared.
//  - kill_IF (synchronous): at the next edge head = tail = count = 0. Any
//    same-cycle push or pop is ignored. kill_IF has priority over everything
//    except reset_i.
//  - Reset (asynchronous, immediate, including mid-operation):
//      head = tail = count = 0, so valid_o = 0, ready_o = 1, count_o = 0,
//      and the head outputs take the empty values above.
//    Storage contents are not reset.
//  - FIFO order is strict; entries are never reordered or dropped except by
//    kill/reset.
// TESTING
//  1. Reset, then push 0x00100093 at PC 0x80000000:
//     -> one cycle later valid_o=1, inst1_o=0x00100093, pc_o=0x80000000,
//        count_o=1.
//  2. stall_ID=1, push 4 entries:
//     -> ready_o=0 after the 4th, count_o=4.
//     A 5th push is ignored, and entries drain in order once stall_ID=0.
//  3. Full queue, push_valid_i=1, stall_ID=0:
//     -> cycle 1 pop only (ready_o=0), count 3.
//     -> afterwards push+pop each cycle, count_o holds at 3.
//     Pointers wrap past index 3 with order preserved.
//  4. 3 entries, then kill_IF=1 with push_valid_i=1:
//     -> next cycle count_o=0, valid_o=0, inst1_o=0x00000013.
//     The pushed entry is not retained.
//  5. Assert reset_i between clock edges with 2 entries held:
//     -> valid_o=0, count_o=0 immediately, before the next edge.
//  6. Empty queue:
//     -> inst1_o=0x00000013, pred_taken_o=0, ready_o=1.
//     A pushed entry with pred_taken_i=1, pred_addr_i=0x80000100 reappears
//     intact on the outputs.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch queue between IF and decode: a circular buffer of fetched
// instructions with PC and branch-prediction info, oldest entry presented to decode.
module fetch_queue #(
  parameter int DEPTH    = 4,
  parameter int INSN_LEN = 32,
  parameter int ADDR_LEN = 32
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     kill_IF,
  input  logic                     push_valid_i,
  input  logic [INSN_LEN-1:0]      inst_i,
  input  logic [ADDR_LEN-1:0]      pc_i,
  input  logic                     pred_taken_i,
  input  logic [ADDR_LEN-1:0]      pred_addr_i,
  output logic                     ready_o,
  input  logic                     stall_ID,
  output logic                     valid_o,
  output logic [INSN_LEN-1:0]      inst1_o,
  output logic [ADDR_LEN-1:0]      pc_o,
  output logic                     pred_taken_o,
  output logic [ADDR_LEN-1:0]      pred_addr_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [INSN_LEN-1:0] NOP = INSN_LEN'(32'h0000_0013);

  typedef struct packed {
    logic [INSN_LEN-1:0] inst;
    logic [ADDR_LEN-1:0] pc;
    logic                pred_taken;
    logic [ADDR_LEN-1:0] pred_addr;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             head_entry;
  logic [PTR_W-1:0]   head_q;
  logic [PTR_W-1:0]   tail_q;
  logic [CNT_W-1:0]   count_q;
  logic               push;
  logic               pop;

  // Full-ness is judged on the registered count only, so a same-cycle pop never admits a push.
  assign ready_o = (count_q < CNT_W'(DEPTH));
  assign valid_o = (count_q != '0);
  assign count_o = count_q;
  assign push    = push_valid_i & ready_o & ~kill_IF;
  assign pop     = valid_o & ~stall_ID & ~kill_IF;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (kill_IF) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + PTR_W'(1);
      if (pop)  head_q <= head_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
    end
  end

  // NOTE: storage is deliberately left unreset; the empty-state output override hides stale data.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[tail_q] <= '{inst: inst_i, pc: pc_i, pred_taken: pred_taken_i, pred_addr: pred_addr_i};
    end
  end

  // NOTE: each output gets a value on every path through this block, so no latch is inferred.
  always_comb begin
    head_entry   = mem[head_q];
    inst1_o      = head_entry.inst;
    pc_o         = head_entry.pc;
    pred_taken_o = head_entry.pred_taken;
    pred_addr_o  = head_entry.pred_addr;
    if (!valid_o) begin
      inst1_o      = NOP;
      pc_o         = '0;
      pred_taken_o = 1'b0;
      pred_addr_o  = '0;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        kill_IF = 1'b0;
  logic        push_valid_i = 1'b0;
  logic [31:0] inst_i = '0;
  logic [31:0] pc_i = '0;
  logic        pred_taken_i = 1'b0;
  logic [31:0] pred_addr_i = '0;
  logic        stall_ID = 1'b0;
  logic        ready_o, valid_o, pred_taken_o;
  logic [31:0] inst1_o, pc_o, pred_addr_o;
  logic [2:0]  count_o;

  fetch_queue #(.DEPTH(DEPTH), .INSN_LEN(32), .ADDR_LEN(32)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .kill_IF(kill_IF), .push_valid_i(push_valid_i),
    .inst_i(inst_i), .pc_i(pc_i), .pred_taken_i(pred_taken_i), .pred_addr_i(pred_addr_i),
    .ready_o(ready_o), .stall_ID(stall_ID), .valid_o(valid_o), .inst1_o(inst1_o),
    .pc_o(pc_o), .pred_taken_o(pred_taken_o), .pred_addr_o(pred_addr_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] pa;
  } ent_t;

  ent_t mq[$];
  int   passed = 0;
  int   total = 0;

  logic [101:0] obs;
  assign obs = {ready_o, valid_o, count_o, inst1_o, pc_o, pred_taken_o, pred_addr_o};

  // Expected observable state from the model: oldest entry at front, NOP when empty.
  function automatic logic [101:0] exp_obs();
    logic [31:0] i, p, a;
    logic t;
    if (mq.size() != 0) begin
      i = mq[0].inst; p = mq[0].pc; t = mq[0].pt; a = mq[0].pa;
    end else begin
      i = 32'h0000_0013; p = '0; t = 1'b0; a = '0;
    end
    return {mq.size() < DEPTH, mq.size() != 0, 3'(mq.size()), i, p, t, a};
  endfunction

  task automatic drive(input logic pv, input logic [31:0] ins, input logic [31:0] pc,
                       input logic pt, input logic [31:0] pa);
    push_valid_i = pv; inst_i = ins; pc_i = pc; pred_taken_i = pt; pred_addr_i = pa;
  endtask

  task automatic drive_rand(input logic pv);
    drive(pv, $urandom, $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC);
  endtask

  // One clock edge with the current inputs; the model follows the queue rules, then settle 1.
  task automatic cycle();
    bit   do_push, do_pop, kill;
    ent_t e;
    do_push = push_valid_i && (mq.size() < DEPTH) && !kill_IF;
    do_pop  = (mq.size() != 0) && !stall_ID && !kill_IF;
    kill    = kill_IF;
    e = '{inst: inst_i, pc: pc_i, pt: pred_taken_i, pa: pred_addr_i};
    @(posedge clk_i);
    if (kill) mq.delete();
    else begin
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(e);
    end
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b0;
    mq.delete();
    #1;
    total++;
    if (obs !== exp_obs()) $display("FAIL reset_state: got %h exp %h", obs, exp_obs());
    else passed++;
    total++;
    if (inst1_o !== 32'h0000_0013) $display("FAIL reset_nop: got %h exp 00000013", inst1_o);
    else passed++;
  endtask

  task automatic test_single_push();
    stall_ID = 1'b1;
    drive(1'b1, 32'h0010_0093, 32'h8000_0000, 1'b0, 32'h0);
    cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    total++;
    if (obs !== exp_obs()) $display("FAIL single_push_model: got %h exp %h", obs, exp_obs());
    else passed++;
    total++;
    if ({valid_o, inst1_o, pc_o, count_o} !== {1'b1, 32'h0010_0093, 32'h8000_0000, 3'd1})
      $display("FAIL single_push: got v=%b i=%h pc=%h c=%0d exp v=1 i=00100093 pc=80000000 c=1",
               valid_o, inst1_o, pc_o, count_o);
    else passed++;
    stall_ID = 1'b0;
    cycle();
    total++;
    if (obs !== exp_obs()) $display("FAIL single_drain: got %h exp %h", obs, exp_obs());
    else passed++;
  endtask

  task automatic test_fill_stall();
    stall_ID = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      drive_rand(1'b1);
      cycle();
      total++;
      if (obs !== exp_obs()) $display("FAIL fill_stall[%0d]: got %h exp %h", i, obs, exp_obs());
      else passed++;
    end
    total++;
    if ({ready_o, count_o} !== {1'b0, 3'd4})
      $display("FAIL fill_full: got ready=%b count=%0d exp ready=0 count=4", ready_o, count_o);
    else passed++;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    stall_ID = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      cycle();
      total++;
      if (obs !== exp_obs()) $display("FAIL drain_order[%0d]: got %h exp %h", i, obs, exp_obs());
      else passed++;
    end
  endtask

  task automatic test_full_stream();
    stall_ID = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      drive_rand(1'b1);
      cycle();
    end
    stall_ID = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive_rand(1'b1);
      cycle();
      total++;
      if (obs !== exp_obs()) $display("FAIL stream[%0d]: got %h exp %h", i, obs, exp_obs());
      else passed++;
      total++;
      if (count_o !== 3'd3) $display("FAIL stream_count[%0d]: got %0d exp 3", i, count_o);
      else passed++;
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      total++;
      if (obs !== exp_obs()) $display("FAIL stream_drain[%0d]: got %h exp %h", i, obs, exp_obs());
      else passed++;
    end
  endtask

  task automatic test_kill();
    stall_ID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_rand(1'b1);
      cycle();
    end
    drive_rand(1'b1);
    kill_IF = 1'b1;
    cycle();
    kill_IF = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    total++;
    if ({valid_o, count_o, inst1_o} !== {1'b0, 3'd0, 32'h0000_0013})
      $display("FAIL kill: got v=%b c=%0d i=%h exp v=0 c=0 i=00000013", valid_o, count_o, inst1_o);
    else passed++;
    cycle();
    total++;
    if (obs !== exp_obs()) $display("FAIL kill_no_retain: got %h exp %h", obs, exp_obs());
    else passed++;
    stall_ID = 1'b0;
  endtask

  task automatic test_async_reset();
    stall_ID = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive_rand(1'b1);
      cycle();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #2 reset_i = 1'b1;
    #1;
    total++;
    if ({valid_o, count_o, ready_o} !== {1'b0, 3'd0, 1'b1})
      $display("FAIL async_reset: got v=%b c=%0d r=%b exp v=0 c=0 r=1", valid_o, count_o, ready_o);
    else passed++;
    mq.delete();
    #1 reset_i = 1'b0;
    stall_ID = 1'b0;
    cycle();
    total++;
    if (obs !== exp_obs()) $display("FAIL after_reset: got %h exp %h", obs, exp_obs());
    else passed++;
  endtask

  task automatic test_empty_pred();
    stall_ID = 1'b0;
    total++;
    if ({inst1_o, pred_taken_o, ready_o} !== {32'h0000_0013, 1'b0, 1'b1})
      $display("FAIL empty_outputs: got i=%h pt=%b r=%b exp i=00000013 pt=0 r=1",
               inst1_o, pred_taken_o, ready_o);
    else passed++;
    drive(1'b1, 32'h0040_006F, 32'h8000_0040, 1'b1, 32'h8000_0100);
    cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    total++;
    if ({inst1_o, pc_o, pred_taken_o, pred_addr_o} !== {32'h0040_006F, 32'h8000_0040, 1'b1, 32'h8000_0100})
      $display("FAIL pred_intact: got i=%h pc=%h pt=%b pa=%h exp i=0040006f pc=80000040 pt=1 pa=80000100",
               inst1_o, pc_o, pred_taken_o, pred_addr_o);
    else passed++;
    cycle();
    total++;
    if (obs !== exp_obs()) $display("FAIL pred_drain: got %h exp %h", obs, exp_obs());
    else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive_rand($urandom_range(0, 9) < 6);
      stall_ID = ($urandom_range(0, 9) < 4);
      kill_IF  = ($urandom_range(0, 19) == 0);
      cycle();
      total++;
      if (obs !== exp_obs()) $display("FAIL random[%0d]: got %h exp %h", i, obs, exp_obs());
      else passed++;
    end
    kill_IF = 1'b0;
    stall_ID = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_fill_stall();
    test_full_stream();
    test_kill();
    test_async_reset();
    test_empty_pred();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
